bus_rr_arbiter: RTL and testbench
=================================

Name: bus_rr_arbiter

Overview:
Registered round-robin arbiter that shares the single master-side bus among NUM_M masters. It sits in front of the bus mux/decoder and drives one-hot grants to the masters. The bus uses m_grant/grant_idx to steer address, write enable, write data and read-data return. A mandatory one-cycle dead cycle separates successive owners so the address/data muxes never switch under a live transfer.

Parameters:
NUM_M, 4, number of requesting masters; must be ≥2.
MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation. Effective only with ARB_PREEMPT_EN; must be ≥2.
IDX_W, $clog2(NUM_M), width of grant_idx; derived, not overridden.

Ports:
clk  input  1  bus clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
m_req  input  NUM_M  per-master request, level; held high for the whole transaction.
m_lock  input  NUM_M  per-master lock; exempts the current owner from preemption.
m_grant  output  NUM_M  one-hot grant, registered; all-zero when bus idle/handoff.
grant_idx  output  IDX_W  index of current owner, registered; retains last owner when no grant.
grant_valid  output  1  high when any m_grant bit is high (registered, equals |m_grant).
bus_busy  output  1  high in GRANT and HANDOFF states.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, m_grant=0, grant_idx=0, grant_valid=0, bus_busy=0, hold_cnt=0, last_idx=NUM_M-1, so master 0 has top priority after reset. Reset mid-grant drops the grant immediately, with no handoff cycle.
- States: IDLE, GRANT, HANDOFF.
- Arbitration: priority rotates and starts at (last_idx+1) mod NUM_M. The winner is the first set bit of m_req in that order. Arbitration is evaluated only in IDLE and HANDOFF.
- IDLE: if m_req≠0, go to GRANT at the next edge. At that edge, set m_grant one-hot to the winner, set grant_idx=winner and last_idx=winner, and clear hold_cnt. Latency is one edge from req sampled high to grant high.
- GRANT, owner req high: stay in GRANT. hold_cnt increments and saturates at MAX_HOLD. Requests from other masters are ignored unless preemption applies.
- GRANT, owner req low at the edge: go to HANDOFF. m_grant=0 and grant_valid=0 at that edge. grant_idx holds.
- HANDOFF lasts exactly one cycle:
  - If m_req≠0, go to GRANT with a new winner. A released master re-requesting competes at lowest priority.
  - Otherwise go to IDLE.
- Simultaneous requests resolve by the rotation order only; there is no fixed priority beyond the reset starting point.
- A request that rises and falls between two edges is not seen.
- Only the owner's m_lock bit is consulted; other lock bits are don't-care.
- m_grant is never multi-hot. The minimum gap between grants to different masters is one cycle.

Optional Feature:
ARB_PREEMPT_EN.
- Defined: in GRANT, if hold_cnt==MAX_HOLD-1, some non-owner m_req bit is set and m_lock[owner]=0, go to HANDOFF even though the owner's req is still high. The owner is then last in rotation. Each preempted grant lasts exactly MAX_HOLD cycles.
- Undefined: no preemption. The owner keeps the bus until it drops req. MAX_HOLD and m_lock are unused, and hold_cnt may be optimised away.

Decomposition:
- Package bus_arb_pkg holds:
  - the state enum {IDLE, GRANT, HANDOFF};
  - the default NUM_M and MAX_HOLD constants;
  - a function returning the index width.
- One sub-module, rr_pick: a combinational rotating-priority picker. Inputs are req[NUM_M] and last_idx. Outputs are winner index and any_req.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
- Reset release with m_req=4'b0001 → m_grant=4'b0001, grant_idx=0 one edge after the first sampling edge. bus_busy=1.
- m_req=4'b1111 held; each owner drops req 3 cycles after its grant → grants in order 0,1,2,3,0, each separated by exactly one all-zero m_grant cycle.
- Owner 0 releases while m_req=4'b0001 is re-raised and master 2 requests → master 2 granted after HANDOFF, then master 0.
- Assert reset_n=0 during a GRANT to master 1 → m_grant=0, grant_valid=0 immediately. After release, state is IDLE and master 0 has priority.
- With ARB_PREEMPT_EN and MAX_HOLD=4, m_req=4'b0011 held:
  - m_lock=0 → master 0 granted 4 cycles, HANDOFF, master 1 granted 4 cycles, repeat.
  - m_lock[0]=1 → master 0 holds the grant indefinitely.
- Without ARB_PREEMPT_EN, m_req=4'b0011 held 40 cycles → master 0 keeps m_grant=4'b0001 throughout. m_grant is never multi-hot (assertion).

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
// Holds the FSM state enum, default sizing constants and the index-width helper.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HANDOFF = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_M    = 4;
    localparam int DEF_MAX_HOLD = 8;

    // A single master would still need a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the search starts just after last_idx
// and wraps, so the previous winner is always considered last.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int IDX_W = idx_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int               cand_i;
    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand_i  = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_M; k++) begin
            cand_i = (int'(last_idx) + k) % NUM_M;
            cand   = IDX_W'(cand_i);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Registered round-robin bus arbiter with a mandatory one-cycle handoff between owners.
// Optional hold-time preemption is enabled by defining ARB_PREEMPT_EN.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_M    = DEF_NUM_M,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int IDX_W    = idx_width(NUM_M)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NUM_M-1:0] m_req,
    input  logic [NUM_M-1:0] m_lock,
    output logic [NUM_M-1:0] m_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             bus_busy
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_e        state, next_state;
    logic [IDX_W-1:0]  last_idx, last_d, idx_d, winner;
    logic [NUM_M-1:0]  grant_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic              any_req, owner_req, preempt;

    rr_pick #(.NUM_M(NUM_M), .IDX_W(IDX_W)) u_pick (
        .req      (m_req),
        .last_idx (last_idx),
        .winner   (winner),
        .any_req  (any_req)
    );

    assign owner_req = m_req[grant_idx];

`ifdef ARB_PREEMPT_EN
    logic others_req;
    // m_grant is one-hot on the owner while in GRANT, so masking it leaves the competitors.
    assign others_req = |(m_req & ~m_grant);
    assign preempt    = (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && others_req && !m_lock[grant_idx];
`else
    logic unused_inputs;
    assign unused_inputs = ^{m_lock, hold_cnt};
    assign preempt       = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (any_req) next_state = GRANT;
            GRANT:   if (!owner_req || preempt) next_state = HANDOFF;
            HANDOFF: next_state = any_req ? GRANT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs; a new owner is only taken when entering GRANT.
    always_comb begin
        grant_d = m_grant;
        idx_d   = grant_idx;
        last_d  = last_idx;
        hold_d  = hold_cnt;
        if (next_state == GRANT && state != GRANT) begin
            grant_d         = '0;
            grant_d[winner] = 1'b1;
            idx_d           = winner;
            last_d          = winner;
            hold_d          = '0;
        end else if (next_state == GRANT) begin
            if (hold_cnt != HOLD_W'(MAX_HOLD)) hold_d = hold_cnt + 1'b1;
        end else begin
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_grant     <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            hold_cnt    <= '0;
            last_idx    <= IDX_W'(NUM_M - 1);
        end else begin
            m_grant     <= grant_d;
            grant_idx   <= idx_d;
            grant_valid <= |grant_d;
            hold_cnt    <= hold_d;
            last_idx    <= last_d;
        end
    end

    assign bus_busy = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural ownership model.
module tb_bus_rr_arbiter;

    localparam int NUM_M    = 4;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] m_req, m_lock, m_grant;
    logic [1:0] grant_idx;
    logic       grant_valid, bus_busy;

    int checks = 0;
    int passed = 0;

    // Behavioural model: phase 0 = bus free, 1 = owned, 2 = dead cycle after an owner.
    int md_phase, md_idx, md_last, md_held;

    bus_rr_arbiter #(.NUM_M(NUM_M), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m_req       (m_req),
        .m_lock      (m_lock),
        .m_grant     (m_grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .bus_busy    (bus_busy)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NUM_M; k++) begin
            if (r[(last + k) % NUM_M]) return (last + k) % NUM_M;
        end
        return -1;
    endfunction

    function automatic logic [7:0] obs();
        return {m_grant, grant_idx, grant_valid, bus_busy};
    endfunction

    function automatic logic [7:0] expv();
        logic [3:0] g;
        g = (md_phase == 1) ? 4'(1 << md_idx) : 4'b0000;
        return {g, 2'(md_idx), md_phase == 1, md_phase != 0};
    endfunction

    task automatic model_reset();
        md_phase = 0;
        md_idx   = 0;
        md_last  = NUM_M - 1;
        md_held  = 0;
    endtask

    task automatic model_edge();
        int  w;
        bit  pre;
        pre = 1'b0;
        if (md_phase == 1) begin
`ifdef ARB_PREEMPT_EN
            pre = (md_held == MAX_HOLD) && ((m_req & ~(4'(1 << md_idx))) != 0) && !m_lock[md_idx];
`endif
            if (!m_req[md_idx] || pre) md_phase = 2;
            else                        md_held++;
        end else begin
            w = pick(m_req, md_last);
            if (w >= 0) begin
                md_phase = 1;
                md_idx   = w;
                md_last  = w;
                md_held  = 1;
            end else begin
                md_phase = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        m_req   = '0;
        m_lock  = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_req   = '0;
        m_lock  = '0;
        model_reset();
        #1;
        checks++;
        if (obs() !== 8'b0000_00_0_0)
            $display("FAIL reset_outputs: got %b, want %b", obs(), 8'b0000_00_0_0);
        else passed++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_first_grant();
        m_req = 4'b0001;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if ({m_grant, grant_idx, bus_busy} !== {4'b0001, 2'd0, 1'b1})
            $display("FAIL first_grant: got grant=%b idx=%0d busy=%b, want grant=0001 idx=0 busy=1",
                     m_grant, grant_idx, bus_busy);
        else passed++;
        m_req = '0;
        repeat (2) begin
            tick();
            checks++;
            if (obs() !== expv()) $display("FAIL first_release: got %b, want %b", obs(), expv());
            else passed++;
        end
    endtask

    task automatic test_rotation();
        int         order[$];
        int         gaps[$];
        int         zeros;
        logic [3:0] prev;
        int         want[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        m_req = 4'b1111;
        zeros = 0;
        prev  = '0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) $display("FAIL rotation_cycle: cycle %0d got %b, want %b", c, obs(), expv());
            else passed++;
            if (m_grant != 0 && m_grant != prev) begin
                if (order.size() > 0) gaps.push_back(zeros);
                order.push_back(int'(grant_idx));
                zeros = 0;
            end else if (m_grant == 0) begin
                zeros++;
            end
            prev = m_grant;
            if (md_phase == 1 && md_held == 3) m_req[md_idx] = 1'b0;
            else if (md_phase == 2)            m_req = 4'b1111;
        end
        checks++;
        if (order.size() != 5) $display("FAIL rotation_count: got %0d grants, want 5", order.size());
        else passed++;
        foreach (order[i]) begin
            checks++;
            if (order[i] != want[i]) $display("FAIL rotation_order: grant %0d got %0d, want %0d", i, order[i], want[i]);
            else passed++;
        end
        foreach (gaps[i]) begin
            checks++;
            if (gaps[i] != 1) $display("FAIL rotation_gap: gap %0d got %0d cycles, want 1", i, gaps[i]);
            else passed++;
        end
        m_req = '0;
        repeat (2) tick();
    endtask

    task automatic test_release_rereq();
        apply_reset();
        m_req = 4'b0001;
        repeat (2) tick();
        m_req = 4'b0100;
        tick();
        checks++;
        if ({m_grant, bus_busy} !== {4'b0000, 1'b1})
            $display("FAIL rereq_handoff: got grant=%b busy=%b, want grant=0000 busy=1", m_grant, bus_busy);
        else passed++;
        m_req = 4'b0101;
        tick();
        checks++;
        if ({m_grant, grant_idx} !== {4'b0100, 2'd2})
            $display("FAIL rereq_second: got grant=%b idx=%0d, want grant=0100 idx=2", m_grant, grant_idx);
        else passed++;
        m_req = 4'b0001;
        tick();
        tick();
        checks++;
        if ({m_grant, grant_idx} !== {4'b0001, 2'd0} || obs() !== expv())
            $display("FAIL rereq_third: got grant=%b idx=%0d, want grant=0001 idx=0", m_grant, grant_idx);
        else passed++;
        m_req = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        m_req = 4'b0010;
        repeat (2) tick();
        checks++;
        if (m_grant !== 4'b0010) $display("FAIL midreset_setup: got grant=%b, want 0010", m_grant);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({m_grant, grant_valid, bus_busy} !== {4'b0000, 1'b0, 1'b0})
            $display("FAIL midreset_drop: got grant=%b valid=%b busy=%b, want 0000 0 0",
                     m_grant, grant_valid, bus_busy);
        else passed++;
        m_req = 4'b0011;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        checks++;
        if ({m_grant, grant_idx} !== {4'b0001, 2'd0} || obs() !== expv())
            $display("FAIL midreset_priority: got grant=%b idx=%0d, want grant=0001 idx=0", m_grant, grant_idx);
        else passed++;
        m_req = '0;
        repeat (2) tick();
    endtask

    task automatic test_hold();
`ifdef ARB_PREEMPT_EN
        int         runs[$];
        int         owners[$];
        int         len;
        logic [3:0] prev;
        apply_reset();
        m_req = 4'b0011;
        len   = 0;
        prev  = '0;
        for (int c = 0; c < 32; c++) begin
            tick();
            checks++;
            if (obs() !== expv()) $display("FAIL preempt_cycle: cycle %0d got %b, want %b", c, obs(), expv());
            else passed++;
            if (m_grant != 0) len++;
            if (m_grant == 0 && prev != 0) begin
                runs.push_back(len);
                owners.push_back(prev == 4'b0001 ? 0 : 1);
                len = 0;
            end
            prev = m_grant;
        end
        checks++;
        if (runs.size() < 4) $display("FAIL preempt_runs: got %0d completed grants, want >= 4", runs.size());
        else passed++;
        foreach (runs[i]) begin
            checks++;
            if (runs[i] != MAX_HOLD || owners[i] != (i % 2))
                $display("FAIL preempt_run: run %0d got len=%0d owner=%0d, want len=%0d owner=%0d",
                         i, runs[i], owners[i], MAX_HOLD, i % 2);
            else passed++;
        end
        apply_reset();
        m_lock = 4'b0001;
        m_req  = 4'b0011;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (m_grant !== 4'b0001 || obs() !== expv())
                $display("FAIL lock_hold: cycle %0d got grant=%b, want 0001", c, m_grant);
            else passed++;
        end
`else
        apply_reset();
        m_req = 4'b0011;
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (m_grant !== 4'b0001 || obs() !== expv())
                $display("FAIL no_preempt: cycle %0d got grant=%b, want 0001", c, m_grant);
            else passed++;
        end
`endif
        m_req  = '0;
        m_lock = '0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < NUM_M; b++) begin
                if ($urandom_range(7) == 0) m_req[b]  = ~m_req[b];
                if ($urandom_range(15) == 0) m_lock[b] = ~m_lock[b];
            end
            tick();
            checks++;
            if (obs() !== expv() || !$onehot0(m_grant))
                $display("FAIL random_cycle: cycle %0d req=%b got %b, want %b", c, m_req, obs(), expv());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_rotation();
        test_release_rereq();
        test_reset_mid_grant();
        test_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
